lcd_stream_parallel_writer: RTL and testbench
=============================================

Name: lcd_stream_parallel_writer

Overview:
- Downstream stage of the LCD data format adapter. It consumes that adapter's 8-bit Avalon-ST packet stream and drives the parallel 8080-style write bus of the LCD controller on the starter board.
- Within each packet, the first byte is a command (RS=0) and every later byte is data (RS=1).
- Chip-select is framed per packet. Write-strobe setup, width and hold are counted in clk cycles and set by parameters.

Parameters:
- SETUP_CYCLES, 2, cycles lcd_data/lcd_rs are stable with lcd_wr_n high before the strobe; legal 1..255
- STROBE_CYCLES, 3, cycles lcd_wr_n is held low; legal 1..255
- HOLD_CYCLES, 2, cycles lcd_data/lcd_rs are held after lcd_wr_n rises; legal 1..255

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- in_ready  output  1  sink ready
- in_valid  input  1  source beat valid
- in_data  input  8  byte
- in_startofpacket  input  1  first beat of packet (command byte)
- in_endofpacket  input  1  last beat of packet
- in_empty  input  1  1 = beat carries no valid byte (legal only with endofpacket)
- lcd_data  output  8  LCD parallel data
- lcd_rs  output  1  0 = command, 1 = data
- lcd_wr_n  output  1  write strobe, active low
- lcd_cs_n  output  1  chip select, active low
- busy  output  1  high while a packet is open or a bus cycle is in progress
- err_orphan  output  1  sticky: a beat arrived outside a packet

Behaviour:
- One clock domain (clk); reset_n is asynchronous, active-low.
- Reset values: in_ready=0, lcd_data=0, lcd_rs=1, lcd_wr_n=1, lcd_cs_n=1, busy=0, err_orphan=0, FSM=IDLE, in_pkt=0. in_ready rises on the first clk edge after reset deasserts.
- All outputs are registered.
- FSM states: IDLE, SETUP, STROBE, HOLD, with one 8-bit cycle counter.
- IDLE:
  - in_ready=1; a beat is accepted on a clk edge with in_valid & in_ready.
  - Accept with sop=1: latch byte, rs<=0, in_pkt<=1, cs_n<=0, go to SETUP. A sop inside an open packet starts a new command; cs_n stays low.
  - Accept with sop=0 and in_pkt=1: latch byte, rs<=1, go to SETUP.
  - Accept with sop=0 and in_pkt=0: discard, err_orphan<=1, stay in IDLE.
  - Accept with eop=1 and empty=1: no bus cycle; in_pkt<=0, cs_n<=1 on the same edge, stay in IDLE. If sop=1 on this beat, no bus cycle occurs and cs_n never falls.
- SETUP: wr_n=1; lcd_data/lcd_rs already valid; lasts SETUP_CYCLES, then STROBE.
- STROBE: wr_n=0 for STROBE_CYCLES, then HOLD.
- HOLD:
  - wr_n=1 for HOLD_CYCLES; lcd_data/lcd_rs unchanged.
  - Then IDLE. If the latched eop=1: in_pkt<=0 and cs_n<=1 on the HOLD→IDLE edge.
- in_ready=0 in SETUP/STROBE/HOLD. in_ready depends only on state, never on in_valid.
- Per-byte bus period: 1 + SETUP_CYCLES + STROBE_CYCLES + HOLD_CYCLES cycles under back-to-back valid (8 with defaults).
- lcd_data/lcd_rs change only on an accept edge, so they never change while wr_n is low.
- busy = in_pkt | (state != IDLE).
- in_empty=1 without eop: treated as an orphan error (err_orphan<=1), beat discarded; packet state is unchanged.
- Reset mid-cycle (including during STROBE): all outputs return to reset values immediately and asynchronously; wr_n rises with no hold time. The partial write is lost and the packet is abandoned.
- err_orphan clears only on reset.

Test Plan:
- Single packet {0x2C sop, 0x11, 0x22 eop}, defaults:
  - 3 bus cycles; rs = 0, 1, 1; wr_n low for exactly 3 cycles each.
  - cs_n low from the first accept edge to the HOLD→IDLE edge of 0x22.
  - in_ready pulses once every 8 cycles.
- Orphan beat 0x55 with no sop: no wr_n pulse, cs_n stays 1, err_orphan=1 and stays 1 through a following valid packet.
- Packet {0xB0 sop, 0x01, 0x00 eop empty=1}: 2 bus cycles; cs_n rises on the accept edge of the empty beat.
- Source-side gaps: in_valid deasserted for 5 cycles between bytes. cs_n stays low and busy stays 1 across the gaps; the bus period restarts at acceptance.
- SETUP=1, STROBE=1, HOLD=1: period is 4 cycles, wr_n low for 1 cycle; check lcd_data is stable from the accept edge through the end of HOLD.
- Assert reset_n during STROBE of the 2nd byte: wr_n=1, cs_n=1, in_ready=0 immediately. After release, a new packet runs correctly with rs=0 on its first byte.

Source files
------------

// File: rtl/lcd_stream_parallel_writer.sv
// Avalon-ST byte stream to 8080-style parallel LCD write bus.
// First byte of each packet is a command (rs=0), later bytes are data (rs=1).
// Chip select spans the whole packet; setup/strobe/hold are clk-cycle counted.
module lcd_stream_parallel_writer #(
    parameter int unsigned SETUP_CYCLES  = 2,
    parameter int unsigned STROBE_CYCLES = 3,
    parameter int unsigned HOLD_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       in_ready,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_startofpacket,
    input  logic       in_endofpacket,
    input  logic       in_empty,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_wr_n,
    output logic       lcd_cs_n,
    output logic       busy,
    output logic       err_orphan
);

    localparam int unsigned CW = 8;
    localparam int unsigned DW = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   data_q, data_d;
    logic            rs_q, rs_d;
    logic            wr_n_q, wr_n_d;
    logic            cs_n_q, cs_n_d;
    logic            rdy_q, rdy_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;
    logic            in_pkt_q, in_pkt_d;
    logic            eop_q, eop_d;

    logic            accept;
    logic            orphan;
    logic            close_empty;

    assign accept      = rdy_q & in_valid & (state_q == IDLE);
    // Empty without eop, or a non-sop beat outside a packet, is discarded.
    assign orphan      = (in_empty & ~in_endofpacket) | (~in_startofpacket & ~in_pkt_q);
    assign close_empty = in_endofpacket & in_empty;

    // State and output registers; reset drops the bus immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            data_q   <= '0;
            rs_q     <= 1'b1;
            wr_n_q   <= 1'b1;
            cs_n_q   <= 1'b1;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            in_pkt_q <= 1'b0;
            eop_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            rs_q     <= rs_d;
            wr_n_q   <= wr_n_d;
            cs_n_q   <= cs_n_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            in_pkt_q <= in_pkt_d;
            eop_q    <= eop_d;
        end
    end

    // Next-state: beat acceptance in IDLE, then setup/strobe/hold countdown.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        rs_d     = rs_q;
        cs_n_d   = cs_n_q;
        err_d    = err_q;
        in_pkt_d = in_pkt_q;
        eop_d    = eop_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (orphan) begin
                        err_d = 1'b1;
                    end else if (close_empty) begin
                        in_pkt_d = 1'b0;
                        cs_n_d   = 1'b1;
                    end else begin
                        data_d   = in_data;
                        rs_d     = ~in_startofpacket;
                        in_pkt_d = 1'b1;
                        cs_n_d   = 1'b0;
                        eop_d    = in_endofpacket;
                        state_d  = SETUP;
                        cnt_d    = CW'(SETUP_CYCLES - 1);
                    end
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = STROBE;
                    cnt_d   = CW'(STROBE_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = CW'(HOLD_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (eop_q) begin
                        in_pkt_d = 1'b0;
                        cs_n_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Registered outputs derived from the upcoming state.
        rdy_d  = (state_d == IDLE);
        wr_n_d = (state_d != STROBE);
        busy_d = in_pkt_d | (state_d != IDLE);
    end

    assign in_ready   = rdy_q;
    assign lcd_data   = data_q;
    assign lcd_rs     = rs_q;
    assign lcd_wr_n   = wr_n_q;
    assign lcd_cs_n   = cs_n_q;
    assign busy       = busy_q;
    assign err_orphan = err_q;

endmodule

// File: tb/tb_lcd_stream_parallel_writer.sv
// Bench for lcd_stream_parallel_writer: default timing (u0) and 1/1/1 timing (u1).
module tb_lcd_stream_parallel_writer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] vld, sop, eop, emp;
    logic [7:0] din [2];
    logic [1:0] rdy, rs, wr, cs, bsy, err;
    logic [7:0] dat [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic chk_on = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lcd_stream_parallel_writer #(.SETUP_CYCLES(2), .STROBE_CYCLES(3), .HOLD_CYCLES(2)) u0 (
        .clk(clk), .reset_n(reset_n), .in_ready(rdy[0]), .in_valid(vld[0]), .in_data(din[0]),
        .in_startofpacket(sop[0]), .in_endofpacket(eop[0]), .in_empty(emp[0]),
        .lcd_data(dat[0]), .lcd_rs(rs[0]), .lcd_wr_n(wr[0]), .lcd_cs_n(cs[0]),
        .busy(bsy[0]), .err_orphan(err[0]));

    lcd_stream_parallel_writer #(.SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1)) u1 (
        .clk(clk), .reset_n(reset_n), .in_ready(rdy[1]), .in_valid(vld[1]), .in_data(din[1]),
        .in_startofpacket(sop[1]), .in_endofpacket(eop[1]), .in_empty(emp[1]),
        .lcd_data(dat[1]), .lcd_rs(rs[1]), .lcd_wr_n(wr[1]), .lcd_cs_n(cs[1]),
        .busy(bsy[1]), .err_orphan(err[1]));

    function automatic int sp(input int i); return (i == 0) ? 2 : 1; endfunction
    function automatic int st(input int i); return (i == 0) ? 3 : 1; endfunction
    function automatic int sh(input int i); return (i == 0) ? 2 : 1; endfunction
    function automatic int per(input int i); return 1 + sp(i) + st(i) + sh(i); endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
        end
    endtask

    // Model: k = cycles since the accept edge of the current byte (0 = idle).
    // Setup covers k=1..S, strobe k=S+1..S+T, hold up to S+T+H, idle again at k=period.
    int         m_k [2];
    logic [1:0] m_rdy, m_pkt, m_cs, m_wr, m_rs, m_err, m_eop;
    logic [7:0] m_dat [2];

    always @(posedge clk or negedge reset_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                m_k[i] <= 0; m_rdy[i] <= 1'b0; m_pkt[i] <= 1'b0; m_cs[i] <= 1'b1;
                m_wr[i] <= 1'b1; m_rs[i] <= 1'b1; m_err[i] <= 1'b0; m_eop[i] <= 1'b0;
                m_dat[i] <= 8'h00;
            end else if (m_k[i] != 0) begin
                if (m_k[i] + 1 == per(i)) begin
                    m_k[i] <= 0; m_wr[i] <= 1'b1; m_rdy[i] <= 1'b1;
                    if (m_eop[i]) begin m_pkt[i] <= 1'b0; m_cs[i] <= 1'b1; end
                end else begin
                    m_k[i]  <= m_k[i] + 1;
                    m_wr[i] <= !((m_k[i] + 1 > sp(i)) && (m_k[i] + 1 <= sp(i) + st(i)));
                end
            end else begin
                m_rdy[i] <= 1'b1;
                if (m_rdy[i] && vld[i]) begin
                    if ((emp[i] && !eop[i]) || (!sop[i] && !m_pkt[i])) begin
                        m_err[i] <= 1'b1;
                    end else if (eop[i] && emp[i]) begin
                        m_pkt[i] <= 1'b0; m_cs[i] <= 1'b1;
                    end else begin
                        m_dat[i] <= din[i]; m_rs[i] <= !sop[i]; m_pkt[i] <= 1'b1;
                        m_cs[i] <= 1'b0; m_eop[i] <= eop[i]; m_k[i] <= 1; m_rdy[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Every-cycle comparison of both DUTs against the model.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (reset_n && chk_on) begin
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("in_ready[%0d]", i), int'(rdy[i]), int'(m_rdy[i]));
                    chk($sformatf("lcd_data[%0d]", i), int'(dat[i]), int'(m_dat[i]));
                    chk($sformatf("lcd_rs[%0d]", i),   int'(rs[i]),  int'(m_rs[i]));
                    chk($sformatf("lcd_wr_n[%0d]", i), int'(wr[i]),  int'(m_wr[i]));
                    chk($sformatf("lcd_cs_n[%0d]", i), int'(cs[i]),  int'(m_cs[i]));
                    chk($sformatf("busy[%0d]", i),     int'(bsy[i]), int'(m_pkt[i] | (m_k[i] != 0)));
                    chk($sformatf("err_orphan[%0d]", i), int'(err[i]), int'(m_err[i]));
                end
            end
        end
    end

    // Bus monitor: logged writes ({rs,data} at wr_n fall), strobe widths, cs_n and in_ready rises.
    int wq0[$], wlen0[$], csr0[$], rdyr0[$];
    int wq1[$], wlen1[$], rdyr1[$];
    logic [1:0] pwr, pcs, prdy;
    int lcnt [2];

    initial begin
        pwr = 2'b11; pcs = 2'b11; prdy = 2'b00; lcnt[0] = 0; lcnt[1] = 0;
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (pwr[i] && !wr[i]) begin
                    if (i == 0) wq0.push_back(int'({rs[0], dat[0]}));
                    else        wq1.push_back(int'({rs[1], dat[1]}));
                    lcnt[i] = 1;
                end else if (!wr[i]) begin
                    lcnt[i]++;
                end
                if (!pwr[i] && wr[i]) begin
                    if (i == 0) wlen0.push_back(lcnt[0]); else wlen1.push_back(lcnt[1]);
                end
                if (i == 0 && !pcs[0] && cs[0]) csr0.push_back(cyc);
                if (!prdy[i] && rdy[i]) begin
                    if (i == 0) rdyr0.push_back(cyc); else rdyr1.push_back(cyc);
                end
            end
            pwr = wr; pcs = cs; prdy = rdy;
        end
    end

    task automatic clear_logs();
        wq0.delete(); wlen0.delete(); csr0.delete(); rdyr0.delete();
        wq1.delete(); wlen1.delete(); rdyr1.delete();
    endtask

    // Present one beat and hold it until accepted; t = cycle stamp of the accept edge.
    task automatic send(input int i, input logic [7:0] b, input logic s, input logic e,
                        input logic m, output int t);
        int n;
        n = 0;
        @(negedge clk);
        din[i] = b; sop[i] = s; eop[i] = e; emp[i] = m; vld[i] = 1'b1;
        while (!rdy[i] && n < 100) begin @(negedge clk); n++; end
        if (!rdy[i]) begin
            total++; bad++;
            $display("FAIL send_timeout[%0d]: in_ready still 0 after %0d cycles, required 1", i, n);
            vld[i] = 1'b0; t = -1;
            return;
        end
        @(posedge clk); #1;
        t = cyc;
        vld[i] = 1'b0;
    endtask

    task automatic wait_rdy(input int i);
        int n;
        n = 0;
        while (!rdy[i] && n < 100) begin @(negedge clk); n++; end
        chk($sformatf("wait_rdy[%0d]", i), int'(rdy[i]), 1);
    endtask

    int t0, t1, t2, te, n;

    initial begin
        reset_n = 1'b0; vld = '0; sop = '0; eop = '0; emp = '0; din[0] = 8'h00; din[1] = 8'h00;
        repeat (3) @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready", int'(rdy[i]), 0); chk("rst_data", int'(dat[i]), 0);
            chk("rst_rs", int'(rs[i]), 1);     chk("rst_wr_n", int'(wr[i]), 1);
            chk("rst_cs_n", int'(cs[i]), 1);   chk("rst_busy", int'(bsy[i]), 0);
            chk("rst_err", int'(err[i]), 0);
        end
        @(negedge clk); reset_n = 1'b1; chk_on = 1'b1;
        @(posedge clk); #1;
        chk("ready_first_edge", int'(rdy[0]), 1);

        // Single packet {2C sop, 11, 22 eop}
        clear_logs();
        send(0, 8'h2C, 1, 0, 0, t0); send(0, 8'h11, 0, 0, 0, t1); send(0, 8'h22, 0, 1, 0, t2);
        repeat (12) @(negedge clk);
        chk("a_nwrites", wq0.size(), 3);
        if (wq0.size() == 3) begin
            chk("a_w0", wq0[0], 'h02C); chk("a_w1", wq0[1], 'h111); chk("a_w2", wq0[2], 'h122);
        end
        foreach (wlen0[j]) chk("a_strobe_len", wlen0[j], 3);
        chk("a_cs_low_span", (csr0.size() == 1) ? csr0[0] - t0 : -1, 23);
        chk("a_nready_rises", rdyr0.size(), 3);
        if (rdyr0.size() == 3) begin
            chk("a_ready_period0", rdyr0[1] - rdyr0[0], 8);
            chk("a_ready_period1", rdyr0[2] - rdyr0[1], 8);
        end

        // Orphan beat, then a valid packet with the error held
        clear_logs();
        send(0, 8'h55, 0, 0, 0, t0);
        repeat (4) @(negedge clk);
        chk("b_nwrites", wq0.size(), 0);
        chk("b_err", int'(err[0]), 1);
        chk("b_cs_n", int'(cs[0]), 1);
        send(0, 8'h2C, 1, 0, 0, t0); send(0, 8'h33, 0, 1, 0, t1);
        repeat (12) @(negedge clk);
        chk("b_err_held", int'(err[0]), 1);
        chk("b_nwrites2", wq0.size(), 2);
        chk("b_err_other", int'(err[1]), 0);

        // Packet closed by an empty eop beat
        clear_logs();
        send(0, 8'hB0, 1, 0, 0, t0); send(0, 8'h01, 0, 0, 0, t1); send(0, 8'h00, 0, 1, 1, te);
        repeat (3) @(negedge clk);
        chk("c_nwrites", wq0.size(), 2);
        if (wq0.size() == 2) begin
            chk("c_w0", wq0[0], 'h0B0); chk("c_w1", wq0[1], 'h101);
        end
        chk("c_cs_rise_at_accept", (csr0.size() == 1) ? csr0[0] - te : -1, 0);
        chk("c_busy", int'(bsy[0]), 0);

        // Source gaps of 5 idle cycles between bytes
        clear_logs();
        send(0, 8'h2A, 1, 0, 0, t0);
        wait_rdy(0); repeat (5) @(negedge clk);
        chk("d_gap_cs_n", int'(cs[0]), 0); chk("d_gap_busy", int'(bsy[0]), 1);
        send(0, 8'h10, 0, 0, 0, t1);
        wait_rdy(0); repeat (5) @(negedge clk);
        chk("d_gap2_cs_n", int'(cs[0]), 0); chk("d_gap2_busy", int'(bsy[0]), 1);
        send(0, 8'h20, 0, 1, 0, t2);
        repeat (12) @(negedge clk);
        chk("d_nwrites", wq0.size(), 3);
        chk("d_period_restart", (rdyr0.size() == 3) ? rdyr0[2] - t2 : -1, 7);

        // Minimum timing instance
        clear_logs();
        send(1, 8'h77, 1, 0, 0, t0); send(1, 8'h88, 0, 0, 0, t1); send(1, 8'h99, 0, 1, 0, t2);
        repeat (8) @(negedge clk);
        chk("e_nwrites", wq1.size(), 3);
        if (wq1.size() == 3) begin
            chk("e_w0", wq1[0], 'h077); chk("e_w1", wq1[1], 'h188); chk("e_w2", wq1[2], 'h199);
        end
        foreach (wlen1[j]) chk("e_strobe_len", wlen1[j], 1);
        if (rdyr1.size() == 3) begin
            chk("e_period0", rdyr1[1] - rdyr1[0], 4);
            chk("e_period1", rdyr1[2] - rdyr1[1], 4);
        end else chk("e_nready_rises", rdyr1.size(), 3);

        // Reset asserted during the strobe of the second byte
        send(0, 8'hA0, 1, 0, 0, t0); send(0, 8'hA1, 0, 0, 0, t1);
        n = 0;
        while (wr[0] && n < 20) begin @(negedge clk); n++; end
        chk("f_in_strobe", int'(wr[0]), 0);
        #2 reset_n = 1'b0;
        #1;
        chk("f_rst_wr_n", int'(wr[0]), 1);  chk("f_rst_cs_n", int'(cs[0]), 1);
        chk("f_rst_ready", int'(rdy[0]), 0); chk("f_rst_busy", int'(bsy[0]), 0);
        @(negedge clk); @(negedge clk); reset_n = 1'b1;
        clear_logs();
        send(0, 8'h3A, 1, 0, 0, t0); send(0, 8'h5B, 0, 1, 0, t1);
        repeat (12) @(negedge clk);
        chk("f_nwrites", wq0.size(), 2);
        if (wq0.size() == 2) begin
            chk("f_w0", wq0[0], 'h03A); chk("f_w1", wq0[1], 'h15B);
        end
        chk("f_cs_n_end", int'(cs[0]), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
